// File: rtl/he_hssi_tx_rr_arb_if.sv
// rtl/he_hssi_tx_rr_arb_if.sv - Source-side and lane-side AXI-Stream bundle for the TX round-robin arbiter
interface he_hssi_tx_rr_arb_if #(
  parameter int NUM_PORTS = 8,
  parameter int DATA_W    = 64,
  parameter int USER_W    = 12,
  parameter int IDX_W     = $clog2(NUM_PORTS)
);

  // Per-source TX streams, packed with source i at slice i.
  logic [NUM_PORTS-1:0]          s_tvalid;
  logic [NUM_PORTS-1:0]          s_tready;
  logic [NUM_PORTS*DATA_W-1:0]   s_tdata;
  logic [NUM_PORTS*DATA_W/8-1:0] s_tkeep;
  logic [NUM_PORTS-1:0]          s_tlast;
  logic [NUM_PORTS*USER_W-1:0]   s_tuser;

  // Shared HSSI TX lane.
  logic                          m_tvalid;
  logic                          m_tready;
  logic [DATA_W-1:0]             m_tdata;
  logic [DATA_W/8-1:0]           m_tkeep;
  logic                          m_tlast;
  logic [USER_W-1:0]             m_tuser;
  logic [IDX_W-1:0]              m_tdest;

  // Traffic sources plus the lane sink: drive the source streams and lane ready.
  modport master (
    output s_tvalid, s_tdata, s_tkeep, s_tlast, s_tuser, m_tready,
    input  s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser, m_tdest
  );

  // The arbiter: consumes the source streams and drives the lane.
  modport slave (
    input  s_tvalid, s_tdata, s_tkeep, s_tlast, s_tuser, m_tready,
    output s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser, m_tdest
  );

endinterface

// File: rtl/he_hssi_tx_rr_arb.sv
// rtl/he_hssi_tx_rr_arb.sv - Packet-level round-robin arbiter sharing one HSSI TX lane among HE-HSSI sources
module he_hssi_tx_rr_arb #(
  parameter int NUM_PORTS = 8,
  parameter int DATA_W    = 64,
  parameter int USER_W    = 12,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] port_en,
  he_hssi_tx_rr_arb_if.slave   bus,
  output logic                 busy,
  output logic [IDX_W-1:0]     cur_port
);

  localparam int KEEP_W = DATA_W / 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   last_grant;

  // Output stage registers.
  logic               m_tvalid_q;
  logic [DATA_W-1:0]  m_tdata_q;
  logic [KEEP_W-1:0]  m_tkeep_q;
  logic               m_tlast_q;
  logic [USER_W-1:0]  m_tuser_q;
  logic [IDX_W-1:0]   m_tdest_q;

  // Arbitration.
  logic [NUM_PORTS-1:0] req;
  logic                 found;
  logic [IDX_W-1:0]     pick;
  logic [IDX_W-1:0]     cand;

  // The granted source, muxed out of the packed buses.
  logic               sel_tvalid;
  logic [DATA_W-1:0]  sel_tdata;
  logic [KEEP_W-1:0]  sel_tkeep;
  logic               sel_tlast;
  logic [USER_W-1:0]  sel_tuser;

  logic               out_free;
  logic               accept;

  // Port index increment that wraps at NUM_PORTS (which need not be a power of two).
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] x);
    if (x == IDX_W'(NUM_PORTS - 1)) begin
      return '0;
    end
    return x + IDX_W'(1);
  endfunction

  assign req = bus.s_tvalid & port_en;

  // Round-robin search: first requester strictly after the last packet owner, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = next_idx(last_grant);
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
      cand = next_idx(cand);
    end
  end

  // Select the granted source's beat from the packed source buses.
  always_comb begin
    sel_tvalid = 1'b0;
    sel_tdata  = '0;
    sel_tkeep  = '0;
    sel_tlast  = 1'b0;
    sel_tuser  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (cur_port == IDX_W'(i)) begin
        sel_tvalid = bus.s_tvalid[i];
        sel_tdata  = bus.s_tdata[i*DATA_W +: DATA_W];
        sel_tkeep  = bus.s_tkeep[i*KEEP_W +: KEEP_W];
        sel_tlast  = bus.s_tlast[i];
        sel_tuser  = bus.s_tuser[i*USER_W +: USER_W];
      end
    end
  end

  // The output register can take a beat when empty or draining this cycle.
  assign out_free = !m_tvalid_q || bus.m_tready;
  assign accept   = (state == ST_PKT) && sel_tvalid && out_free;

  // Only the granted source sees ready; it never depends on any s_tvalid.
  always_comb begin
    bus.s_tready = '0;
    if (state == ST_PKT) begin
      bus.s_tready[cur_port] = out_free;
    end
  end

  assign bus.m_tvalid = m_tvalid_q;
  assign bus.m_tdata  = m_tdata_q;
  assign bus.m_tkeep  = m_tkeep_q;
  assign bus.m_tlast  = m_tlast_q;
  assign bus.m_tuser  = m_tuser_q;
  assign bus.m_tdest  = m_tdest_q;

  // Grant FSM and output stage; a grant is held from the first beat through tlast.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= IDX_W'(NUM_PORTS - 1);
      cur_port   <= '0;
      busy       <= 1'b0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tkeep_q  <= '0;
      m_tlast_q  <= 1'b0;
      m_tuser_q  <= '0;
      m_tdest_q  <= '0;
    end else begin
      if (accept) begin
        m_tvalid_q <= 1'b1;
        m_tdata_q  <= sel_tdata;
        m_tkeep_q  <= sel_tkeep;
        m_tlast_q  <= sel_tlast;
        m_tuser_q  <= sel_tuser;
        m_tdest_q  <= cur_port;
      end else if (bus.m_tready) begin
        m_tvalid_q <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (found) begin
            cur_port <= pick;
            busy     <= 1'b1;
            state    <= ST_PKT;
          end
        end
        ST_PKT: begin
          if (accept && sel_tlast) begin
            last_grant <= cur_port;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_he_hssi_tx_rr_arb.sv
// tb/tb_he_hssi_tx_rr_arb.sv - Self-checking bench for the HSSI TX round-robin arbiter
module tb_he_hssi_tx_rr_arb;

  localparam int NP = 8;
  localparam int DW = 64;
  localparam int UW = 12;
  localparam int IW = 3;
  localparam int KW = DW / 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  typedef struct {
    int    dest;
    beat_t b;
  } exp_t;

  typedef struct {
    int            cyc;
    int            dest;
    logic          last;
    logic [DW-1:0] data;
  } out_t;

  typedef struct {
    int            prev;
    logic [NP-1:0] req;
    logic [NP-1:0] en;
    int            exp;
  } arb_vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NP-1:0] port_en = '1;
  logic          busy;
  logic [IW-1:0] cur_port;

  he_hssi_tx_rr_arb_if #(.NUM_PORTS(NP), .DATA_W(DW), .USER_W(UW), .IDX_W(IW)) bus ();

  he_hssi_tx_rr_arb #(.NUM_PORTS(NP), .DATA_W(DW), .USER_W(UW), .IDX_W(IW)) dut (
    .clk      (clk),
    .rst      (rst),
    .port_en  (port_en),
    .bus      (bus.slave),
    .busy     (busy),
    .cur_port (cur_port)
  );

  always #5 clk = ~clk;

  beat_t src_q [NP][$];
  exp_t  exp_q [$];
  out_t  out_log [$];
  int    n_vec = 0;
  int    n_miss = 0;
  int    cyc = 0;
  bit    rst_pend = 1'b0;
  bit    bp_mode = 1'b0;
  int    rise_cyc [NP];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic do_reset();
    bp_mode  = 1'b0;
    rst_pend = 1'b1;
    tick(2);
    port_en = '1;
  endtask

  task automatic push_pkt(input int p, input int nbeats, input logic [DW-1:0] d0);
    beat_t b;
    for (int i = 0; i < nbeats; i++) begin
      b.data = d0 + DW'(i);
      b.keep = KW'($urandom);
      b.user = UW'($urandom);
      b.last = (i == nbeats - 1);
      src_q[p].push_back(b);
    end
  endtask

  task automatic wait_log(input string name, input int n, input int budget);
    int k;
    k = 0;
    while (out_log.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    check(name, 64'(out_log.size() >= n), 64'd1);
  endtask

  // Source drivers, scoreboard and lane monitor share one process so handshakes are seen consistently.
  initial begin : drv_mon
    logic [NP-1:0]    acc_next;
    logic [NP-1:0]    prev_valid;
    logic [NP-1:0]    tv, tl;
    logic [NP*DW-1:0] td;
    logic [NP*KW-1:0] tk;
    logic [NP*UW-1:0] tu;
    bit               stall_prev;
    logic [DW-1:0]    snap_data;
    logic [63:0]      snap_ctl;
    exp_t             e;
    out_t             o;
    beat_t            b;
    bus.s_tvalid = '0;
    bus.s_tdata  = '0;
    bus.s_tkeep  = '0;
    bus.s_tlast  = '0;
    bus.s_tuser  = '0;
    bus.m_tready = 1'b1;
    acc_next   = '0;
    prev_valid = '0;
    stall_prev = 1'b0;
    snap_data  = '0;
    snap_ctl   = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (stall_prev) begin
          check("stall_data", bus.m_tdata, snap_data);
          check("stall_ctl", {39'd0, bus.m_tvalid, bus.m_tkeep, bus.m_tuser, bus.m_tlast, bus.m_tdest}, snap_ctl);
        end
        if (bus.m_tvalid && bus.m_tready) begin
          o.cyc  = cyc;
          o.dest = int'(bus.m_tdest);
          o.last = bus.m_tlast;
          o.data = bus.m_tdata;
          out_log.push_back(o);
          check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_data", bus.m_tdata, e.b.data);
            check("sb_ctl", {40'd0, bus.m_tkeep, bus.m_tuser, bus.m_tlast, bus.m_tdest},
                  {40'd0, e.b.keep, e.b.user, e.b.last, IW'(e.dest)});
          end
        end
        stall_prev = bus.m_tvalid && !bus.m_tready;
        snap_data  = bus.m_tdata;
        snap_ctl   = {39'd0, bus.m_tvalid, bus.m_tkeep, bus.m_tuser, bus.m_tlast, bus.m_tdest};
        for (int p = 0; p < NP; p++) begin
          if (bus.s_tvalid[p] && !prev_valid[p]) rise_cyc[p] = cyc;
        end
        acc_next = bus.s_tvalid & bus.s_tready;
      end else begin
        stall_prev = 1'b0;
        acc_next   = '0;
      end
      prev_valid = bus.s_tvalid;

      @(posedge clk);
      #1;
      if (rst) begin
        exp_q.delete();
        for (int p = 0; p < NP; p++) src_q[p].delete();
      end
      rst      = rst_pend;
      rst_pend = 1'b0;
      for (int p = 0; p < NP; p++) begin
        if (acc_next[p] && src_q[p].size() > 0) begin
          b      = src_q[p].pop_front();
          e.dest = p;
          e.b    = b;
          exp_q.push_back(e);
        end
      end
      tv = '0; tl = '0; td = '0; tk = '0; tu = '0;
      for (int p = 0; p < NP; p++) begin
        if (src_q[p].size() > 0) begin
          b              = src_q[p][0];
          tv[p]          = 1'b1;
          td[p*DW +: DW] = b.data;
          tk[p*KW +: KW] = b.keep;
          tu[p*UW +: UW] = b.user;
          tl[p]          = b.last;
        end
      end
      bus.s_tvalid = tv;
      bus.s_tdata  = td;
      bus.s_tkeep  = tk;
      bus.s_tlast  = tl;
      bus.s_tuser  = tu;
      bus.m_tready = bp_mode ? ~bus.m_tready : 1'b1;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    arb_vec_t vecs [10];
    int       base;
    vecs[0] = '{-1, 8'hFF, 8'hFF, 0};
    vecs[1] = '{-1, 8'h11, 8'hFF, 0};
    vecs[2] = '{ 0, 8'h11, 8'hFF, 4};
    vecs[3] = '{ 3, 8'h09, 8'hFF, 0};
    vecs[4] = '{ 5, 8'hE0, 8'hFF, 6};
    vecs[5] = '{ 7, 8'h80, 8'hFF, 7};
    vecs[6] = '{ 2, 8'h0C, 8'hF8, 3};
    vecs[7] = '{ 6, 8'hFF, 8'h06, 1};
    vecs[8] = '{ 1, 8'h03, 8'hFF, 0};
    vecs[9] = '{-1, 8'h84, 8'h80, 7};

    tick(1);
    check("rst_m_tvalid", bus.m_tvalid, 0);
    check("rst_s_tready", bus.s_tready, 0);
    check("rst_busy", busy, 0);
    check("rst_cur_port", cur_port, 0);
    check("rst_m_tdata", bus.m_tdata, 0);
    check("rst_m_ctl", {bus.m_tlast, bus.m_tdest, bus.m_tkeep, bus.m_tuser}, 0);

    // Arbitration table: optional prior owner, then a simultaneous request set.
    for (int v = 0; v < 10; v++) begin
      do_reset();
      if (vecs[v].prev >= 0) begin
        base = out_log.size();
        push_pkt(vecs[v].prev, 1, 64'hA000 + 64'(v * 16 + vecs[v].prev));
        wait_log("arb_prev_wait", base + 1, 20);
        tick(3);
      end
      port_en = vecs[v].en;
      base = out_log.size();
      for (int p = 0; p < NP; p++) begin
        if (vecs[v].req[p]) push_pkt(p, 1, 64'hB000 + 64'(v * 16 + p));
      end
      wait_log("arb_wait", base + 1, 20);
      if (out_log.size() > base) check($sformatf("arb_vec%0d", v), out_log[base].dest, vecs[v].exp);
    end

    // Single 4-beat packet on port 3.
    do_reset();
    base = out_log.size();
    push_pkt(3, 4, 64'h1);
    wait_log("single_wait", base + 4, 30);
    if (out_log.size() >= base + 4) begin
      check("single_start", out_log[base].cyc - rise_cyc[3], 2);
      for (int i = 0; i < 4; i++) begin
        check($sformatf("single_dest%0d", i), out_log[base+i].dest, 3);
        check($sformatf("single_data%0d", i), out_log[base+i].data, i + 1);
        check($sformatf("single_cyc%0d", i), out_log[base+i].cyc - out_log[base].cyc, i);
        check($sformatf("single_last%0d", i), out_log[base+i].last, (i == 3));
      end
    end
    tick(3);
    check("single_busy_after", busy, 0);
    check("single_count", out_log.size() - base, 4);

    // All-port contention with 2-beat packets.
    do_reset();
    base = out_log.size();
    for (int p = 0; p < NP; p++) begin
      push_pkt(p, 2, 64'h100 * 64'(p + 1));
      push_pkt(p, 2, 64'h100 * 64'(p + 1) + 64'h10);
    end
    wait_log("cont_wait", base + 18, 80);
    if (out_log.size() >= base + 18) begin
      for (int k = 0; k < 9; k++) begin
        check($sformatf("cont_dest%0da", k), out_log[base+2*k].dest, k % 8);
        check($sformatf("cont_dest%0db", k), out_log[base+2*k+1].dest, k % 8);
        check($sformatf("cont_intra%0d", k), out_log[base+2*k+1].cyc - out_log[base+2*k].cyc, 1);
        if (k < 8) check($sformatf("cont_gap%0d", k), out_log[base+2*k+2].cyc - out_log[base+2*k+1].cyc, 2);
      end
    end

    // Backpressure: 8-beat packet on port 1 with m_tready toggling.
    do_reset();
    bp_mode = 1'b1;
    base = out_log.size();
    push_pkt(1, 8, 64'hC0DE_0000);
    wait_log("bp_wait", base + 8, 60);
    tick(4);
    check("bp_count", out_log.size() - base, 8);
    if (out_log.size() >= base + 8) begin
      check("bp_last", out_log[base+7].last, 1);
      check("bp_dest", out_log[base].dest, 1);
    end
    bp_mode = 1'b0;

    // Port 2 disabled mid-packet while port 5 waits.
    do_reset();
    base = out_log.size();
    push_pkt(2, 5, 64'hD200);
    push_pkt(5, 2, 64'hD500);
    push_pkt(2, 1, 64'hD2F0);
    wait_log("en_wait1", base + 1, 20);
    port_en[2] = 1'b0;
    wait_log("en_wait2", base + 7, 40);
    tick(15);
    check("en_total", out_log.size() - base, 7);
    if (out_log.size() >= base + 7) begin
      for (int i = 0; i < 7; i++) check($sformatf("en_dest%0d", i), out_log[base+i].dest, (i < 5) ? 2 : 5);
    end
    check("en_busy", busy, 0);

    // Reset pulsed mid-packet on port 4.
    do_reset();
    base = out_log.size();
    push_pkt(4, 6, 64'hE400);
    wait_log("rstm_wait", base + 3, 20);
    rst_pend = 1'b1;
    tick(2);
    check("rstm_m_tvalid", bus.m_tvalid, 0);
    check("rstm_s_tready", bus.s_tready, 0);
    check("rstm_busy", busy, 0);
    base = out_log.size();
    push_pkt(4, 2, 64'hE480);
    push_pkt(0, 2, 64'hE000);
    wait_log("rstm_wait2", base + 4, 30);
    if (out_log.size() >= base + 4) begin
      check("rstm_first", out_log[base].dest, 0);
      check("rstm_second", out_log[base+2].dest, 4);
    end

    // Alternating single-beat packets on ports 6 and 7.
    do_reset();
    base = out_log.size();
    push_pkt(6, 1, 64'h60);
    push_pkt(7, 1, 64'h70);
    push_pkt(6, 1, 64'h61);
    push_pkt(7, 1, 64'h71);
    wait_log("sb1_wait", base + 4, 30);
    if (out_log.size() >= base + 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("sb1_dest%0d", i), out_log[base+i].dest, (i % 2 == 0) ? 6 : 7);
        check($sformatf("sb1_last%0d", i), out_log[base+i].last, 1);
        if (i > 0) check($sformatf("sb1_gap%0d", i), out_log[base+i].cyc - out_log[base+i-1].cyc, 2);
      end
    end

    do_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
